// File: rtl/cpu_uart_io.sv
// cpu_uart_io: CPU-facing serial I/O responder.
//   Transmit: each accepted write has its low byte sent as an 8N1 UART frame.
//   Receive : incoming 8N1 frames land in r_data and raise irr until the CPU acks.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   w_req, w_data   CPU write request pulse and payload (bits [7:0] are sent)
//   w_busy          transmitter busy; w_req is ignored while high
//   r_data, irr     last received byte (zero-extended) and pending-byte interrupt
//   ack             CPU acknowledge of the pending byte
//   uart_tx         serial output, idles high
//   uart_rx         serial input, asynchronous to clk
module cpu_uart_io #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_req,
  input  logic [31:0] w_data,
  output logic        w_busy,
  output logic [31:0] r_data,
  output logic        irr,
  input  logic        ack,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Only the low byte is transmitted.
  logic unused_wdata_s;
  assign unused_wdata_s = ^w_data[31:8];

  // ---------------- transmit path ----------------
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q, tx_busy_d;

  // TX state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_byte_q  <= 8'd0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // TX next state; the line level is registered so it changes on the bit boundary edge.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (w_req) begin
          tx_byte_d  = w_data[7:0];
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_idx_d   = 3'd0;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
        end else begin
          tx_line_d = 1'b1;
          tx_busy_d = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_DATA;
          tx_line_d  = tx_byte_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_line_d = tx_byte_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
          tx_busy_d  = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_cnt_d   = '0;
        tx_line_d  = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------- receive path ----------------
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             irr_q, irr_d;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      irr_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      irr_q      <= irr_d;
    end
  end

  // RX next state. A framing error leaves rx_s low, so rx_prev_q must see a 1 again
  // before another falling edge can start a frame.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    irr_d      = irr_q;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = 3'd0;
          if (rx_s_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
        rx_cnt_d   = '0;
      end
    endcase

    // A completed byte beats a simultaneous ack.
    if ((rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST) && rx_s_q) begin
      rx_data_d = rx_shift_q;
      irr_d     = 1'b1;
    end else if (ack) begin
      irr_d = 1'b0;
    end else begin
      irr_d = irr_q;
    end
  end

  assign uart_tx = tx_line_q;
  assign w_busy  = tx_busy_q;
  assign r_data  = {24'd0, rx_data_q};
  assign irr     = irr_q;

endmodule

// File: tb/tb_cpu_uart_io.sv
// Self-checking bench for cpu_uart_io at 4 clocks per bit. A frame-level model
// (frame bit array indexed by elapsed cycles, queue of expected byte arrivals)
// is compared against the DUT on every negedge; directed checks pin literals.
module tb_cpu_uart_io;

  localparam int CPB = 4;
  // Arrival edge of a received byte, counted from the edge after which the line
  // falls: 2 synchronizer stages + 1 edge detect + half start bit + 8 data bits + stop bit.
  localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_req = 1'b0;
  logic [31:0] w_data = 32'd0;
  logic        w_busy;
  logic [31:0] r_data;
  logic        irr;
  logic        ack = 1'b0;
  logic        uart_tx;
  logic        uart_rx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        chk_en = 1'b0;

  int total = 0;
  int bad = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  cpu_uart_io #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .w_req(w_req), .w_data(w_data),
    .w_busy(w_busy), .r_data(r_data), .irr(irr), .ack(ack),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int          cyc = 0;        // number of rising edges seen so far
  int          tx_k = -1;      // cycles since frame acceptance, -1 when idle
  logic [9:0]  tx_frame = 10'h3FF;
  logic        irr_m = 1'b0;
  logic [31:0] rdata_m = 32'd0;
  int          due_q[$];
  logic [7:0]  byte_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      tx_k    <= -1;
      irr_m   <= 1'b0;
      rdata_m <= 32'd0;
      due_q.delete();
      byte_q.delete();
    end else begin
      if (tx_k < 0) begin
        if (w_req) begin
          tx_k     <= 0;
          tx_frame <= {1'b1, w_data[7:0], 1'b0};
          if (loop_en) begin
            due_q.push_back(cyc + 1 + RX_LAT);
            byte_q.push_back(w_data[7:0]);
          end
        end
      end else if (tx_k == 10 * CPB - 1) begin
        tx_k <= -1;
      end else begin
        tx_k <= tx_k + 1;
      end
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        rdata_m <= {24'd0, byte_q[0]};
        irr_m   <= 1'b1;
        void'(due_q.pop_front());
        void'(byte_q.pop_front());
      end else if (ack) begin
        irr_m <= 1'b0;
      end
    end
  end

  function automatic logic exp_tx();
    if (tx_k < 0) return 1'b1;
    return tx_frame[tx_k / CPB];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
      check("m_w_busy",  {31'd0, w_busy},  {31'd0, (tx_k >= 0)});
      check("m_irr",     {31'd0, irr},     {31'd0, irr_m});
      check("m_r_data",  r_data,           rdata_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on uart_rx; entered and left at a negedge.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    if (stop_bit) begin
      due_q.push_back(cyc + RX_LAT);
      byte_q.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      tick(CPB);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pulse_write(input logic [31:0] d);
    w_req  = 1'b1;
    w_data = d;
    tick(1);
    w_req  = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    logic [0:9] tx_pat;
    int busy_cnt;
    tx_pat = 10'b0101001011;

    // Reset
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_w_busy",  {31'd0, w_busy},  32'd0);
    check("rst_irr",     {31'd0, irr},     32'd0);
    check("rst_r_data",  r_data,           32'h0000_0000);
    tick(3);

    // TX frame with an ignored second request at cycle 10
    pulse_write(32'hDEAD_BEA5);
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (k < 40) check("tx_pattern", {31'd0, uart_tx}, {31'd0, tx_pat[k / CPB]});
      if (w_busy) busy_cnt++;
      if (k == 9) begin
        w_req  = 1'b1;
        w_data = 32'h0000_00FF;
      end
      if (k == 10) w_req = 1'b0;
      tick(1);
    end
    check("tx_busy_cycles", busy_cnt, 32'd40);
    check("tx_idle_line", {31'd0, uart_tx}, 32'd1);

    // RX byte and ack
    send_rx(8'h3C, 1'b1);
    tick(3);
    check("rx_irr", {31'd0, irr}, 32'd1);
    check("rx_data", r_data, 32'h0000_003C);
    pulse_ack();
    check("ack_irr", {31'd0, irr}, 32'd0);
    check("ack_data_hold", r_data, 32'h0000_003C);
    tick(4);

    // Glitch, then framing error
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(12);
    check("glitch_irr", {31'd0, irr}, 32'd0);
    send_rx(8'h55, 1'b0);
    tick(12);
    check("frame_err_irr", {31'd0, irr}, 32'd0);
    check("frame_err_data", r_data, 32'h0000_003C);

    // Overrun
    send_rx(8'h11, 1'b1);
    tick(5);
    send_rx(8'h22, 1'b1);
    tick(5);
    check("overrun_data", r_data, 32'h0000_0022);
    check("overrun_irr", {31'd0, irr}, 32'd1);

    // Ack on the completion edge of 0x33
    send_rx(8'h33, 1'b1);
    pulse_ack();
    check("collide_irr", {31'd0, irr}, 32'd1);
    check("collide_data", r_data, 32'h0000_0033);
    pulse_ack();
    check("collide_ack_irr", {31'd0, irr}, 32'd0);
    tick(4);

    // Loopback
    loop_en = 1'b1;
    tick(2);
    pulse_write(32'h0000_00A7);
    tick(50);
    check("loop_irr", {31'd0, irr}, 32'd1);
    check("loop_data", r_data, 32'h0000_00A7);
    pulse_ack();
    check("loop_ack_irr", {31'd0, irr}, 32'd0);

    // Reset at cycle 15 of a looped-back TX frame
    pulse_write(32'h0000_0000);
    tick(14);
    rst_n = 1'b0;
    tick(1);
    check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_w_busy",  {31'd0, w_busy},  32'd0);
    rst_n = 1'b1;
    tick(60);
    check("midrst_irr", {31'd0, irr}, 32'd0);
    check("midrst_data", r_data, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
